// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The master side issues operations; the slave side is the riscv_muldiv unit.
interface riscv_muldiv_if #(
    parameter int XLEN = 32
);
    logic            i_md_valid;
    logic            o_md_ready;
    logic [2:0]      i_md_op;
    logic [XLEN-1:0] i_md_a;
    logic [XLEN-1:0] i_md_b;
    logic            i_md_kill;
    logic            o_md_done;
    logic [XLEN-1:0] o_md_result;

    modport master (
        output i_md_valid, i_md_op, i_md_a, i_md_b, i_md_kill,
        input  o_md_ready, o_md_done, o_md_result
    );

    modport slave (
        input  i_md_valid, i_md_op, i_md_a, i_md_b, i_md_kill,
        output o_md_ready, o_md_done, o_md_result
    );
endinterface

// File: rtl/riscv_muldiv.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit with flush kill.
// Define RISCV_MULDIV_FAST_MUL_EN to route multiplies through a single-cycle combinational multiplier.
module riscv_muldiv #(
    parameter int  XLEN = 32,
    localparam int CNTW = $clog2(XLEN) + 1
) (
    input logic         i_clk,
    input logic         i_rst,
    riscv_muldiv_if.slave md
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    endfunction

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_neg, b_neg, div_by_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qr;

    assign a_neg       = a_is_signed(md.i_md_op) & md.i_md_a[XLEN-1];
    assign b_neg       = b_is_signed(md.i_md_op) & md.i_md_b[XLEN-1];
    assign a_mag       = a_neg ? -md.i_md_a : md.i_md_a;
    assign b_mag       = b_neg ? -md.i_md_b : md.i_md_b;
    assign div_by_zero = md.i_md_op[2] && (md.i_md_b == '0);
    assign div_ovf     = md.i_md_op[2] && !md.i_md_op[0] && (md.i_md_a == MinNeg) &&
                         (md.i_md_b == '1);

`ifdef RISCV_MULDIV_FAST_MUL_EN
    // Raw operands sit in hi_q/lo_q while in StFix; sign-extend per op and keep the low 2*XLEN.
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{a_is_signed(op_q) & hi_q[XLEN-1]}}, hi_q};
    assign fast_b    = {{XLEN{b_is_signed(op_q) & lo_q[XLEN-1]}}, lo_q};
    assign fast_prod = fast_a * fast_b;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        result_d = result_q;

        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        rem_shift = {hi_q, lo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, mcand_q};
        prod      = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        qr        = op_q[1] ? hi_q : lo_q;
        if (neg_q) qr = -qr;

        unique case (state_q)
            StIdle: begin
                if (md.i_md_valid && !md.i_md_kill) begin
                    op_d  = md.i_md_op;
                    // Remainder follows the dividend sign; products and quotients the sign xor.
                    neg_d = (md.i_md_op[2] && md.i_md_op[1]) ? a_neg : (a_neg ^ b_neg);
                    if (div_by_zero) begin
                        result_d = md.i_md_op[1] ? md.i_md_a : '1;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = md.i_md_op[1] ? '0 : MinNeg;
                        state_d  = StDone;
`ifdef RISCV_MULDIV_FAST_MUL_EN
                    end else if (!md.i_md_op[2]) begin
                        hi_d    = md.i_md_a;
                        lo_d    = md.i_md_b;
                        state_d = StFix;
`endif
                    end else begin
                        cnt_d   = CNTW'(XLEN);
                        hi_d    = '0;
                        lo_d    = md.i_md_op[2] ? a_mag : b_mag;
                        mcand_d = md.i_md_op[2] ? b_mag : a_mag;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (md.i_md_kill) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (op_q[2]) begin
                        // Restoring step: hi holds the partial remainder, lo shifts in quotient bits.
                        if (!rem_diff[XLEN]) begin
                            hi_d = rem_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = rem_shift[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNTW'(1)) state_d = StFix;
                end
            end
            StFix: begin
                if (md.i_md_kill) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[2])             result_d = qr;
                    else if (op_q == 3'b000) result_d = prod[XLEN-1:0];
                    else                     result_d = prod[2*XLEN-1:XLEN];
`ifdef RISCV_MULDIV_FAST_MUL_EN
                    if (!op_q[2]) begin
                        result_d = (op_q == 3'b000) ? fast_prod[XLEN-1:0]
                                                    : fast_prod[2*XLEN-1:XLEN];
                    end
`endif
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign md.o_md_ready  = (state_q == StIdle);
    assign md.o_md_done   = (state_q == StDone) && !md.i_md_kill;
    assign md.o_md_result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (XLEN=32) against an arithmetic reference model.
// Honours RISCV_MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_riscv_muldiv;
    localparam int XLEN = 32;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = XLEN + 2;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    riscv_muldiv_if #(.XLEN(XLEN)) mif ();

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .md    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up, wp;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        up  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return up[31:0];
            3'd1: begin sp = sa * sb; wp = sp; return wp[63:32]; end
            3'd2: begin sp = sa * longint'({32'd0, b}); wp = sp; return wp[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) return MulLat;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one request from an idle unit, scrambles inputs after the accept edge and
    // returns the result with the accept-to-done latency (accept edge counts as 1).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        mif.i_md_valid = 1'b1;
        mif.i_md_op    = op;
        mif.i_md_a     = a;
        mif.i_md_b     = b;
        @(posedge clk);
        #1;
        mif.i_md_valid = 1'b0;
        mif.i_md_op    = 3'($urandom_range(0, 7));
        mif.i_md_a     = $urandom;
        mif.i_md_b     = $urandom;
        lat = 1;
        while (!mif.o_md_done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = mif.o_md_result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mif.o_md_ready !== 1'b1 || mif.o_md_done !== 1'b0 || mif.o_md_result !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b result=%h expected 1 0 00000000",
                     mif.o_md_ready, mif.o_md_done, mif.o_md_result);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        vec_t        v[$];
        logic [31:0] res;
        int          lat;
        v.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
        v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        v.push_back('{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000});
        v.push_back('{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        v.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA});
        v.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE});
        v.push_back('{3'd5, 32'd100, 32'd7, 32'd14});
        v.push_back('{3'd7, 32'd100, 32'd7, 32'd2});
        v.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF});
        v.push_back('{3'd6, 32'd5, 32'd0, 32'd5});
        v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        v.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp) begin
                errors++;
                $display("FAIL directed_result[%0d] op=%0d: got %h expected %h",
                         i, v[i].op, res, v[i].exp);
            end
            checks++;
            if (lat != ref_latency(v[i].op, v[i].a, v[i].b)) begin
                errors++;
                $display("FAIL directed_latency[%0d] op=%0d: got %0d expected %0d",
                         i, v[i].op, lat, ref_latency(v[i].op, v[i].a, v[i].b));
            end
            @(posedge clk);
            #1;
            checks++;
            if (mif.o_md_done !== 1'b0 || mif.o_md_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_pulse[%0d]: done=%b ready=%b expected 0 1",
                         i, mif.o_md_done, mif.o_md_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_op(op, a, b, res, lat);
            checks++;
            if (res !== ref_result(op, a, b) || lat != ref_latency(op, a, b)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                         i, op, a, b, res, lat, ref_result(op, a, b), ref_latency(op, a, b));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int          lat;
        int          seen;
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        @(posedge clk);
        #1;
        // Kill during CALC, ten cycles after the accept.
        mif.i_md_valid = 1'b1;
        mif.i_md_op    = 3'd4;
        mif.i_md_a     = 32'd12345;
        mif.i_md_b     = 32'd7;
        @(posedge clk);
        #1;
        mif.i_md_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        mif.i_md_kill = 1'b1;
        @(posedge clk);
        #1;
        mif.i_md_kill = 1'b0;
        checks++;
        if (mif.o_md_ready !== 1'b1 || mif.o_md_done !== 1'b0 || mif.o_md_result !== 32'd14) begin
            errors++;
            $display("FAIL kill_calc: ready=%b done=%b result=%h expected 1 0 0000000e",
                     mif.o_md_ready, mif.o_md_done, mif.o_md_result);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mif.o_md_done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL kill_no_done: got %0d done pulses expected 0", seen);
        end
        // Kill in IDLE must block the accept.
        mif.i_md_valid = 1'b1;
        mif.i_md_kill  = 1'b1;
        mif.i_md_op    = 3'd0;
        mif.i_md_a     = 32'd9;
        mif.i_md_b     = 32'd9;
        @(posedge clk);
        #1;
        mif.i_md_valid = 1'b0;
        mif.i_md_kill  = 1'b0;
        checks++;
        if (mif.o_md_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_idle_block: ready=%b expected 1", mif.o_md_ready);
        end
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        checks++;
        if (res !== 32'd12 || lat != MulLat) begin
            errors++;
            $display("FAIL kill_then_mul: got %h lat %0d expected 0000000c lat %0d",
                     res, lat, MulLat);
        end
        @(posedge clk);
        #1;
        // Kill while the done pulse is up: pulse suppressed, result already registered.
        run_op(3'd5, 32'd1000, 32'd10, res, lat);
        mif.i_md_kill = 1'b1;
        #1;
        checks++;
        if (mif.o_md_done !== 1'b0) begin
            errors++;
            $display("FAIL kill_done_mask: done=%b expected 0", mif.o_md_done);
        end
        @(posedge clk);
        #1;
        mif.i_md_kill = 1'b0;
        checks++;
        if (mif.o_md_ready !== 1'b1 || mif.o_md_result !== 32'd100) begin
            errors++;
            $display("FAIL kill_done_state: ready=%b result=%h expected 1 00000064",
                     mif.o_md_ready, mif.o_md_result);
        end
        // Kill in FIX: the result register must not load.
        mif.i_md_valid = 1'b1;
        mif.i_md_op    = 3'd5;
        mif.i_md_a     = 32'd999;
        mif.i_md_b     = 32'd3;
        @(posedge clk);
        #1;
        mif.i_md_valid = 1'b0;
        repeat (XLEN) begin
            @(posedge clk);
            #1;
        end
        mif.i_md_kill = 1'b1;
        @(posedge clk);
        #1;
        mif.i_md_kill = 1'b0;
        checks++;
        if (mif.o_md_ready !== 1'b1 || mif.o_md_done !== 1'b0 || mif.o_md_result !== 32'd100) begin
            errors++;
            $display("FAIL kill_fix: ready=%b done=%b result=%h expected 1 0 00000064",
                     mif.o_md_ready, mif.o_md_done, mif.o_md_result);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        int          seen;
        mif.i_md_valid = 1'b1;
        mif.i_md_op    = 3'd5;
        mif.i_md_a     = 32'd1000;
        mif.i_md_b     = 32'd3;
        @(posedge clk);
        #1;
        mif.i_md_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mif.o_md_ready !== 1'b1 || mif.o_md_done !== 1'b0 || mif.o_md_result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b done=%b result=%h expected 1 0 00000000",
                     mif.o_md_ready, mif.o_md_done, mif.o_md_result);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mif.o_md_done || !mif.o_md_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL async_reset_quiet: got %0d busy/done cycles expected 0", seen);
        end
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        checks++;
        if (res !== 32'd12) begin
            errors++;
            $display("FAIL async_reset_recover: got %h expected 0000000c", res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        prev_done;
        int          accepts, dones, budget;
        accepts   = 0;
        dones     = 0;
        prev_done = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (prev_done) begin
                checks++;
                if (mif.o_md_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_after_done cyc=%0d: ready=%b expected 1",
                             cyc, mif.o_md_ready);
                end
            end
            prev_done = mif.o_md_done;
            if (mif.o_md_done) begin
                dones++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~mif.o_md_result;
                checks++;
                if (mif.o_md_result !== exp) begin
                    errors++;
                    $display("FAIL b2b_result cyc=%0d: got %h expected %h", cyc,
                             mif.o_md_result, exp);
                end
            end
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            mif.i_md_valid = 1'b1;
            mif.i_md_op    = op;
            mif.i_md_a     = a;
            mif.i_md_b     = b;
            if (mif.o_md_ready) begin
                exp_q.push_back(ref_result(op, a, b));
                accepts++;
            end
            @(posedge clk);
            #1;
        end
        mif.i_md_valid = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            if (mif.o_md_done) begin
                dones++;
                exp = exp_q.pop_front();
                checks++;
                if (mif.o_md_result !== exp) begin
                    errors++;
                    $display("FAIL b2b_drain_result: got %h expected %h", mif.o_md_result, exp);
                end
            end
            @(posedge clk);
            #1;
            budget++;
        end
        repeat (40) begin
            if (mif.o_md_done) dones++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dones != accepts || accepts < 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d dones for %0d accepts expected equal (>=2)",
                     dones, accepts);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        mif.i_md_valid = 1'b0;
        mif.i_md_kill  = 1'b0;
        mif.i_md_op    = 3'd0;
        mif.i_md_a     = 32'd0;
        mif.i_md_b     = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
- Iterative RV32M/RV64M multiply/divide unit. Sits beside the integer ALU in the execute stage.
- Accepts one operation through a valid/ready handshake and computes it over multiple cycles (radix-2, one bit per cycle).
- Returns the result with a one-cycle done pulse.
- Parametrised in XLEN. Supports a kill input so the pipeline can abort on flush.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNTW, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_md_valid  input  1  request valid.
- o_md_ready  output  1  unit idle, able to accept.
- i_md_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_md_a  input  XLEN  rs1 operand.
- i_md_b  input  XLEN  rs2 operand.
- i_md_kill  input  1  abort the in-flight operation.
- o_md_done  output  1  one-cycle pulse, result valid.
- o_md_result  output  XLEN  result.

Behaviour:
- Reset: async, active-high. State=IDLE, o_md_ready=1, o_md_done=0, o_md_result=0, counter=0, internal registers=0.
- Accept: a request is accepted on a rising edge where i_md_valid && o_md_ready. Operands and op are latched at that edge; inputs are ignored afterwards.
- o_md_ready = (state==IDLE), registered-state decode only, never combinational on i_md_valid.
- States:
  - IDLE: on accept, go to CALC, or to DONE for the special cases below.
  - CALC: one iteration per cycle; counter loads XLEN and decrements each cycle. When counter reaches 1, go to FIX.
  - FIX: one cycle; applies sign correction (two's-complement negate) and selects the low/high half or the quotient/remainder. Result is registered here; go to DONE.
  - DONE: o_md_done=1 for exactly this cycle; return to IDLE.
- Latency, normal path: accept edge N → o_md_done high during the cycle after edge N+XLEN+1. This is XLEN+2 cycles from accept; 34 for XLEN=32.
- Signed handling:
  - Operands are converted to magnitude.
  - Signed operands: MULH uses both; MULHSU uses a only; DIV and REM use both.
  - Result negated when the signs differ (product/quotient), or when the dividend is negative (remainder).
- Multiply: shift-add over a 2*XLEN accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring shift-subtract producing quotient and remainder.
- Special cases are detected at accept and go IDLE→DONE directly, with o_md_done on the cycle after the accept edge:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = i_md_a.
  - Signed overflow (a=most negative, b=-1): DIV = most negative; REM = 0.
- o_md_result holds its value after DONE until the next FIX/special-case load. It is not cleared on return to IDLE.
- Kill:
  - i_md_kill sampled high in CALC, FIX or DONE → next state IDLE, o_md_done forced 0 that cycle, o_md_result unchanged.
  - i_md_kill high in IDLE blocks the accept that cycle.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- Back-to-back: a new request may be accepted on the edge that leaves DONE→IDLE+1 (ready rises the cycle after DONE).

Optional Feature:
- Macro: RISCV_MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single combinational 2*XLEN signed multiplier, registered in FIX.
  - Multiplies go IDLE→FIX→DONE, so o_md_done comes 2 cycles after accept.
  - Divides are unchanged.
- Undefined: all operations use the iterative path described above. No multiplier is inferred.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) → result 0xFFFFFFEB; done exactly 34 cycles after accept (2 with RISCV_MULDIV_FAST_MUL_EN).
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHSU same operands → 0xC0000000. MULHU same operands → 0x40000000.
- DIV a=-20, b=3 → 0xFFFFFFFA (-6). REM same operands → 0xFFFFFFFE (-2). DIVU a=100, b=7 → 14. REMU same operands → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF. REM a=5, b=0 → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. All three: done 1 cycle after accept.
- Kill: accept DIV, assert i_md_kill 10 cycles later → no done pulse, ready=1 next cycle, o_md_result keeps its previous value. Then accept MUL 3×4 → 12.
- Assert i_rst asynchronously mid-CALC → outputs return to reset values without a clock edge. Hold i_md_valid during busy → exactly one done per accepted request.
